ftoi_pipe: RTL and testbench
============================

Name: ftoi_pipe

Overview:
- Pipelined IEEE-754 single-precision float to signed 32-bit integer converter.
- Inverse-direction companion of the FPU adder and int-to-float paths: consumes packed floats and produces integers for the integer register file.
- Three-stage pipeline with valid/ready handshake on both sides and full backpressure.
- Round-to-nearest-even by default, with saturation on overflow or NaN.

Parameters:
- RNE_EN, 1, rounding mode: 1 = round to nearest even; 0 = truncate toward zero (C cast semantics).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- x  in  32  float operand {s, e[7:0], m[22:0]}.
- in_valid  in  1  x is valid this cycle.
- in_ready  out  1  block accepts x this cycle.
- y  out  32  signed integer result.
- ovf  out  1  invalid/overflow flag, qualified by out_valid.
- out_valid  out  1  y and ovf are valid.
- out_ready  in  1  consumer accepts y this cycle.

Behaviour:
- Reset (synchronous, active-high): all stage valid bits = 0, out_valid = 0, y = 0, ovf = 0; in_ready = 1 in the first cycle after reset.
- Reset mid-operation: in-flight items are discarded, not flushed to the output.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - Stalled: every stage register holds its value.
  - Not stalled: the pipeline advances one stage per cycle, and bubbles advance too.
- Handshake:
  - Accept on in_valid & in_ready.
  - Deliver on out_valid & out_ready.
  - Latency is exactly 3 cycles from accept to out_valid when unstalled.
  - Throughput is 1 per cycle; order is preserved; no loss or duplication under any out_ready pattern.
- S1 (unpack):
  - Latch s, e, and mantissa with hidden bit: mh = {e!=0, m} (24 bits).
  - Compute the signed 9-bit shift sh = e - 150.
  - Classify:
    - nan = (e==255 & m!=0)
    - big = (e>=158)
    - tiny = (e<126)
- S2 (shift):
  - sh >= 0: mag = mh << sh (32 bits; valid only when !big); g = 0, sticky = 0.
  - sh < 0: mag = mh >> -sh; g = the last bit shifted out; sticky = OR of all lower shifted-out bits.
  - Shift distances above 24 produce mag = 0, g = 0, sticky = |mh.
  - Denormals and zero give mag = 0 and result 0.
- S3 (round/sign/saturate):
  - RNE_EN = 1: inc = g & (sticky | mag[0]). RNE_EN = 0: inc = 0.
  - r = mag + inc (33 bits).
  - y = s ? -r : r.
  - Result 0 is always 0x00000000; there is no negative zero in integers.
- Saturation (ovf = 1):
  - nan: y = 0x7FFFFFFF.
  - big & !s, which includes +inf: y = 0x7FFFFFFF.
  - big & s, except exactly 0xCF000000: y = 0x80000000.
  - x == 0xCF000000 (-2^31) is exact: y = 0x80000000, ovf = 0.
  - Rounding can never overflow, because the largest float below 2^31 is an integer.
- Boundaries:
  - e == 126 (0.5 <= |x| < 1): RNE gives 0 for exactly 0.5, ±1 above it.
  - tiny: y = 0, ovf = 0.

Decomposition:
- fpu_pkg holds:
  - Field widths (EXP_W = 8, MAN_W = 23).
  - BIAS = 127; FTOI_SH0 = 150; FTOI_BIG_E = 158.
  - INT_MAX = 32'h7FFFFFFF; INT_MIN = 32'h80000000.
  - Packed float struct typedef.
- One sub-module: ftoi_round, the combinational S3 logic (inc decision, negate, saturate mux).
  - Shared later with the fcvt variants (floor, ceil).

Test Plan:
- Rounding, RNE_EN = 1, one item per cycle, out_ready = 1:
  - 0x3FC00000 (1.5) -> 0x00000002.
  - 0x40200000 (2.5) -> 0x00000002.
  - 0xC0200000 (-2.5) -> 0xFFFFFFFE.
  - 0x3F000000 (0.5) -> 0x00000000.
  - Each arrives exactly 3 cycles after accept.
- Truncate mode, RNE_EN = 0: 0x3FF00000 (1.875) -> 1; 0xBFF00000 -> 0xFFFFFFFF.
- Saturation, checking y and ovf:
  - 0x4F000000 -> 0x7FFFFFFF, ovf = 1.
  - 0xCF000000 -> 0x80000000, ovf = 0.
  - 0xCF000001 -> 0x80000000, ovf = 1.
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, ovf = 1.
  - 0xFF800000 (-inf) -> 0x80000000, ovf = 1.
- Small and special inputs, each giving y = 0, ovf = 0: 0x00000001 (denormal), 0x80000000 (-0), 0x3EFFFFFF.
- Backpressure:
  - Stream 1.0, 2.0, 3.0, 4.0, 5.0 back-to-back; hold out_ready low for cycles 4-6.
  - Required: in_ready = 0 during the stall, outputs hold stable, sequence 1..5 delivered in order, no drops or repeats.
- Reset mid-stream: assert rst for 1 cycle with 3 items in flight.
  - Required next cycle: out_valid = 0, y = 0, in_ready = 1.
  - None of the pre-reset items ever appear on the output.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float field widths, conversion constants and packed float layout.
package fpu_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [7:0] BIAS = 8'd127;
    localparam logic [8:0] FTOI_SH0 = 9'd150;
    localparam logic [7:0] FTOI_BIG_E = 8'd158;
    localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] INT_MIN = 32'h80000000;

    typedef struct packed {
        logic s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } float_t;
endpackage

// File: rtl/ftoi_pipe_if.sv
// ftoi_pipe_if: float-in / integer-out valid-ready stream pair.
interface ftoi_pipe_if;
    logic [31:0] x;
    logic in_valid;
    logic in_ready;
    logic [31:0] y;
    logic ovf;
    logic out_valid;
    logic out_ready;

    modport master(output x, in_valid, out_ready, input in_ready, y, ovf, out_valid);
    modport slave(input x, in_valid, out_ready, output in_ready, y, ovf, out_valid);
endinterface

// File: rtl/ftoi_round.sv
// ftoi_round: rounding increment, sign application and saturation for float-to-int.
module ftoi_round
    import fpu_pkg::*;
#(
    parameter bit RNE_EN = 1'b1
) (
    input  logic        s,
    input  logic [31:0] mag,
    input  logic        g,
    input  logic        st,
    input  logic        nan,
    input  logic        big,
    input  logic        exact,
    output logic [31:0] y,
    output logic        ovf
);
    logic inc;
    logic [31:0] r;

    // r cannot wrap: every float below 2^31 with a fraction is far below it
    always_comb begin
        inc = RNE_EN && g && (st || mag[0]);
        r = mag + {31'd0, inc};
        ovf = nan || (big && !exact);
        y = (nan || (big && !s)) ? INT_MAX : big ? INT_MIN : s ? -r : r;
    end
endmodule

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: three-stage float32 to int32 converter (unpack, shift, round) with backpressure.
module ftoi_pipe
    import fpu_pkg::*;
#(
    parameter bit RNE_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    ftoi_pipe_if.slave io
);
    float_t f;
    logic stall;
    logic v1, s1, nan1, big1, tiny1, ex1;
    logic [23:0] mh1;
    logic signed [8:0] sh1;
    logic v2, s2, nan2, big2, ex2, g2, st2;
    logic [31:0] mag2;
    logic [8:0] d;
    logic [47:0] ext;
    logic [31:0] mag;
    logic g, st;
    logic [31:0] yr;
    logic ovfr;

    assign f = io.x;
    assign stall = io.out_valid & ~io.out_ready;
    assign io.in_ready = ~stall;

    // right shifts keep the shifted-out bits in ext[23:0] for guard/sticky
    always_comb begin
        d = -sh1;
        ext = {mh1, 24'd0} >> d[4:0];
        mag = !sh1[8] ? {8'd0, mh1} << sh1[4:0] : d > 9'd24 ? 32'd0 : {8'd0, ext[47:24]};
        g = sh1[8] && d <= 9'd24 && ext[23];
        st = sh1[8] && (d > 9'd24 ? |mh1 : |ext[22:0]);
    end

    ftoi_round #(.RNE_EN(RNE_EN)) u_round (
        .s(s2),
        .mag(mag2),
        .g(g2),
        .st(st2),
        .nan(nan2),
        .big(big2),
        .exact(ex2),
        .y(yr),
        .ovf(ovfr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            io.out_valid <= 1'b0;
            io.y <= '0;
            io.ovf <= 1'b0;
        end else if (!stall) begin
            v1 <= io.in_valid;
            s1 <= f.s;
            mh1 <= {f.e != 8'd0, f.m};
            sh1 <= {1'b0, f.e} - FTOI_SH0;
            nan1 <= f.e == 8'hFF && f.m != '0;
            big1 <= f.e >= FTOI_BIG_E;
            tiny1 <= f.e < BIAS - 8'd1;
            ex1 <= io.x == {1'b1, FTOI_BIG_E, 23'd0};
            v2 <= v1;
            s2 <= s1;
            mag2 <= tiny1 ? '0 : mag;
            g2 <= g & ~tiny1;
            st2 <= st & ~tiny1;
            nan2 <= nan1;
            big2 <= big1;
            ex2 <= ex1;
            io.out_valid <= v2;
            io.y <= yr;
            io.ovf <= ovfr;
        end
    end
endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe: drives RNE and truncating instances in lockstep and checks against an arithmetic model.
module tb_ftoi_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ftoi_pipe_if a ();
    ftoi_pipe_if b ();

    ftoi_pipe #(.RNE_EN(1'b1)) dut_r (.clk(clk), .rst(rst), .io(a.slave));
    ftoi_pipe #(.RNE_EN(1'b0)) dut_t (.clk(clk), .rst(rst), .io(b.slave));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] acc_x[$];
    int acc_t[$];
    int got_t[$];
    logic [31:0] gr_y[$], gt_y[$];
    logic gr_o[$], gt_o[$];

    localparam int ND = 19;
    localparam logic [31:0] DX [ND] = '{
        32'h3FC00000, 32'h40200000, 32'hC0200000, 32'h3F000000, 32'h3FF00000, 32'hBFF00000,
        32'h4F000000, 32'hCF000000, 32'hCF000001, 32'h7FC00000, 32'hFF800000, 32'h00000001,
        32'h80000000, 32'h3EFFFFFF, 32'h3F000001, 32'hBF400000, 32'h3F800000, 32'h7F800000,
        32'h4EFFFFFF};
    localparam logic [31:0] DR [ND] = '{
        32'h00000002, 32'h00000002, 32'hFFFFFFFE, 32'h00000000, 32'h00000002, 32'hFFFFFFFE,
        32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF,
        32'h7FFFFF80};
    localparam logic [31:0] DT [ND] = '{
        32'h00000001, 32'h00000002, 32'hFFFFFFFE, 32'h00000000, 32'h00000001, 32'hFFFFFFFF,
        32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001, 32'h7FFFFFFF,
        32'h7FFFFF80};
    localparam logic DO [ND] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] BP [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

    // value = mh * 2^(e-150); round by comparing the dropped remainder with one half
    function automatic logic [32:0] model(input logic [31:0] x, input bit rne);
        logic s;
        int e, d;
        longint mh, ip, rem, half;
        s = x[31];
        e = int'(x[30:23]);
        mh = (e != 0) ? (longint'(1) << 23) + longint'(x[22:0]) : longint'(x[22:0]);
        if (e == 255 && x[22:0] != 0) return {1'b1, 32'h7FFFFFFF};
        if (x == 32'hCF000000) return {1'b0, 32'h80000000};
        if (e >= 158) return {1'b1, s ? 32'h80000000 : 32'h7FFFFFFF};
        if (e >= 150) ip = mh << (e - 150);
        else begin
            d = 150 - e;
            if (d > 25) ip = 0;
            else begin
                ip = mh >> d;
                rem = mh - (ip << d);
                half = longint'(1) << (d - 1);
                if (rne && (rem > half || (rem == half && ip[0]))) ip = ip + 1;
            end
        end
        return {1'b0, s ? 32'(-ip) : 32'(ip)};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(118, 160));
        if ($urandom_range(0, 3) == 0) r[22:0] = r[22:0] & 23'h7F0000;
        return r;
    endfunction

    task automatic clear_q();
        acc_x.delete(); acc_t.delete(); got_t.delete();
        gr_y.delete(); gt_y.delete(); gr_o.delete(); gt_o.delete();
    endtask

    // one clock: drive at edge+1, record handshakes at the falling edge
    task automatic cycle(input logic v, input logic [31:0] xv, input logic ordy, output logic ir, output logic [31:0] yo);
        a.in_valid = v; b.in_valid = v;
        a.x = xv; b.x = xv;
        a.out_ready = ordy; b.out_ready = ordy;
        @(negedge clk);
        ir = a.in_ready;
        yo = a.y;
        if (a.out_valid && a.out_ready) begin
            gr_y.push_back(a.y); gr_o.push_back(a.ovf);
            gt_y.push_back(b.y); gt_o.push_back(b.ovf);
            got_t.push_back(cyc);
        end
        if (a.in_valid && a.in_ready) begin
            acc_x.push_back(xv); acc_t.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        a.in_valid = 0; b.in_valid = 0; a.x = 0; b.x = 0; a.out_ready = 0; b.out_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a.out_valid !== 1'b0 || b.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b/%b want 0", a.out_valid, b.out_valid);
        end
        checks++;
        if (a.y !== 32'd0 || a.ovf !== 1'b0) begin
            errors++; $display("FAIL reset_y got %h ovf %b want 00000000 ovf 0", a.y, a.ovf);
        end
        checks++;
        if (a.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", a.in_ready);
        end
        rst = 0;
    endtask

    task automatic test_directed();
        logic ir;
        logic [31:0] yo;
        clear_q();
        for (int i = 0; i < ND; i++) cycle(1'b1, DX[i], 1'b1, ir, yo);
        repeat (6) cycle(1'b0, 32'd0, 1'b1, ir, yo);
        checks++;
        if (gr_y.size() != ND) begin
            errors++; $display("FAIL directed_count got %0d want %0d", gr_y.size(), ND);
        end
        for (int i = 0; i < ND && i < gr_y.size(); i++) begin
            checks++;
            if (gr_y[i] !== DR[i] || gr_o[i] !== DO[i]) begin
                errors++; $display("FAIL rne x=%h got %h ovf %b want %h ovf %b", DX[i], gr_y[i], gr_o[i], DR[i], DO[i]);
            end
            checks++;
            if (gt_y[i] !== DT[i] || gt_o[i] !== DO[i]) begin
                errors++; $display("FAIL trunc x=%h got %h ovf %b want %h ovf %b", DX[i], gt_y[i], gt_o[i], DT[i], DO[i]);
            end
            checks++;
            if (got_t[i] - acc_t[i] != 3) begin
                errors++; $display("FAIL latency x=%h got %0d want 3", DX[i], got_t[i] - acc_t[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic ir;
        logic [31:0] yo, y_hold;
        int idx, n;
        clear_q();
        idx = 0;
        y_hold = '0;
        for (int c = 0; c < 16; c++) begin
            n = acc_x.size();
            cycle(idx < 5, BP[idx < 5 ? idx : 0], !(c >= 4 && c <= 6), ir, yo);
            if (acc_x.size() > n) idx++;
            if (c >= 4 && c <= 6) begin
                checks++;
                if (ir !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready c=%0d got %b want 0", c, ir);
                end
            end
            if (c == 4) y_hold = yo;
            if (c == 5 || c == 6) begin
                checks++;
                if (yo !== y_hold) begin
                    errors++; $display("FAIL stall_hold c=%0d got %h want %h", c, yo, y_hold);
                end
            end
        end
        checks++;
        if (gr_y.size() != 5) begin
            errors++; $display("FAIL bp_count got %0d want 5", gr_y.size());
        end
        for (int i = 0; i < 5 && i < gr_y.size(); i++) begin
            checks++;
            if (gr_y[i] !== 32'(i + 1) || gr_o[i] !== 1'b0) begin
                errors++; $display("FAIL bp_order i=%0d got %h ovf %b want %h ovf 0", i, gr_y[i], gr_o[i], 32'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ir;
        logic [31:0] yo;
        clear_q();
        for (int i = 0; i < 3; i++) cycle(1'b1, BP[i], 1'b1, ir, yo);
        rst = 1;
        cycle(1'b0, 32'd0, 1'b0, ir, yo);
        rst = 0;
        checks++;
        if (a.out_valid !== 1'b0 || a.y !== 32'd0 || a.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got valid %b y %h ready %b want 0 00000000 1", a.out_valid, a.y, a.in_ready);
        end
        clear_q();
        repeat (8) cycle(1'b0, 32'd0, 1'b1, ir, yo);
        checks++;
        if (gr_y.size() != 0) begin
            errors++; $display("FAIL mid_reset_leak got %0d items want 0", gr_y.size());
        end
        cycle(1'b1, 32'h40000000, 1'b1, ir, yo);
        repeat (5) cycle(1'b0, 32'd0, 1'b1, ir, yo);
        checks++;
        if (gr_y.size() != 1 || gr_y[0] !== 32'd2) begin
            errors++; $display("FAIL post_reset got %0d items first %h want 1 item 00000002", gr_y.size(), gr_y.size() > 0 ? gr_y[0] : 32'hX);
        end
    endtask

    task automatic test_random();
        logic ir;
        logic [31:0] yo;
        logic [32:0] er, et;
        clear_q();
        for (int c = 0; c < 3000 && acc_x.size() < 200; c++)
            cycle($urandom_range(0, 3) != 0, rand_float(), $urandom_range(0, 3) != 0, ir, yo);
        for (int c = 0; c < 50 && gr_y.size() < acc_x.size(); c++)
            cycle(1'b0, 32'd0, 1'b1, ir, yo);
        checks++;
        if (gr_y.size() != acc_x.size() || acc_x.size() != 200) begin
            errors++; $display("FAIL random_count got %0d delivered %0d accepted want 200", gr_y.size(), acc_x.size());
        end
        for (int i = 0; i < gr_y.size() && i < acc_x.size(); i++) begin
            er = model(acc_x[i], 1'b1);
            et = model(acc_x[i], 1'b0);
            checks++;
            if (gr_y[i] !== er[31:0] || gr_o[i] !== er[32]) begin
                errors++; $display("FAIL rand_rne x=%h got %h ovf %b want %h ovf %b", acc_x[i], gr_y[i], gr_o[i], er[31:0], er[32]);
            end
            checks++;
            if (gt_y[i] !== et[31:0] || gt_o[i] !== et[32]) begin
                errors++; $display("FAIL rand_trunc x=%h got %h ovf %b want %h ovf %b", acc_x[i], gt_y[i], gt_o[i], et[31:0], et[32]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
